// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared encodings and helpers for the data-memory arbiter
package dmem_arb_pkg;

  localparam int DMEM_NPORTS = 2;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_P0   = 2'b01,
    OWN_P1   = 2'b10
  } owner_e;

  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_P0   = 2'b01;
  localparam logic [1:0] RD_P1   = 2'b10;

  // Tie-break from IDLE: 1 selects port 1, 0 selects port 0.
  function automatic logic tie_pick(input logic last, input logic rr_en);
    return rr_en & ~last;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with burst cap and read-return routing
// Optional round-robin IDLE tie-break: define DMEM_ARB_RR_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef DMEM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  owner_e                   r_owner;
  owner_e                   w_owner_nxt;
  logic [CNT_W-1:0]         r_burst_cnt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic [CNT_W-1:0]         w_cnt_sat;
  logic                     r_last;
  logic [1:0]               r_rd_owner;
  logic [DMEM_NPORTS-1:0]   w_gnt;

  assign w_cnt_sat = (r_burst_cnt == CNT_MAX) ? r_burst_cnt : r_burst_cnt + CNT_ONE;

  always_comb begin
    w_gnt       = '0;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_burst_cnt;
    case (r_owner)
      OWN_IDLE: begin
        if (req0 && req1) begin
          w_gnt = tie_pick(r_last, RR_EN) ? 2'b10 : 2'b01;
        end else if (req0) begin
          w_gnt = 2'b01;
        end else if (req1) begin
          w_gnt = 2'b10;
        end
        w_owner_nxt = w_gnt[1] ? OWN_P1 : (w_gnt[0] ? OWN_P0 : OWN_IDLE);
        w_cnt_nxt   = (|w_gnt) ? CNT_ONE : '0;
      end
      OWN_P0: begin
        if (req0 && (!req1 || r_burst_cnt < CNT_MAX)) begin
          w_gnt     = 2'b01;
          w_cnt_nxt = w_cnt_sat;
        end else if (req1) begin
          w_gnt       = 2'b10;
          w_owner_nxt = OWN_P1;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_owner_nxt = OWN_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      OWN_P1: begin
        if (req1 && (!req0 || r_burst_cnt < CNT_MAX)) begin
          w_gnt     = 2'b10;
          w_cnt_nxt = w_cnt_sat;
        end else if (req0) begin
          w_gnt       = 2'b01;
          w_owner_nxt = OWN_P0;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_owner_nxt = OWN_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_owner_nxt = OWN_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if (rst) begin
      w_gnt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= OWN_IDLE;
      r_burst_cnt <= '0;
      r_last      <= 1'b1;
      r_rd_owner  <= RD_NONE;
    end else begin
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_cnt_nxt;
      if (|w_gnt) begin
        r_last <= w_gnt[1];
      end
      if (w_gnt[0] && !we0) begin
        r_rd_owner <= RD_P0;
      end else if (w_gnt[1] && !we1) begin
        r_rd_owner <= RD_P1;
      end else begin
        r_rd_owner <= RD_NONE;
      end
    end
  end

  assign gnt0      = w_gnt[0];
  assign gnt1      = w_gnt[1];
  assign mem_en    = |w_gnt;
  assign mem_we    = w_gnt[0] ? we0    : (w_gnt[1] ? we1    : 1'b0);
  assign mem_addr  = w_gnt[0] ? addr0  : (w_gnt[1] ? addr1  : '0);
  assign mem_wdata = w_gnt[0] ? wdata0 : (w_gnt[1] ? wdata1 : '0);

  // Gating with rst drops the return of a read granted just before reset.
  assign rvalid0 = (r_rd_owner == RD_P0) && !rst;
  assign rvalid1 = (r_rd_owner == RD_P1) && !rst;
  assign rdata0  = rvalid0 ? mem_rdata : '0;
  assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int MB = 4;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rdata0(rdata0), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Memory seen by the DUT: 1-cycle synchronous read, address = word index.
  logic [31:0] bmem [0:255];
  always @(posedge clk) begin
    if (mem_en && mem_we) bmem[mem_addr[7:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= bmem[mem_addr[7:0]];
    else                   mem_rdata <= $urandom;
  end

  // Reference model: who owns the memory, length of the current grant streak,
  // last granted port, the pending read return and a shadow copy of memory.
  logic [31:0] ref_mem [0:255];
  int          m_owner = -1;
  int          m_streak = 0;
  int          m_last = 1;
  int          m_rd = -1;
  logic [31:0] m_rd_data = '0;
  int          w;
  logic        e_we;
  logic [31:0] e_addr, e_wdata;

  function automatic int pick(input bit r0, input bit r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1)  return 0;
    if (r1 && !r0)  return 1;
    if (m_owner < 0) return RR ? 1 - m_last : 0;
    return (m_streak < MB) ? m_owner : 1 - m_owner;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("m_rst_gnt0", gnt0, 0);
      chk("m_rst_gnt1", gnt1, 0);
      chk("m_rst_men", mem_en, 0);
      chk("m_rst_rv0", rvalid0, 0);
      chk("m_rst_rv1", rvalid1, 0);
      m_owner = -1; m_streak = 0; m_last = 1; m_rd = -1;
    end else begin
      chk("m_rvalid0", rvalid0, m_rd == 0);
      chk("m_rvalid1", rvalid1, m_rd == 1);
      chk("m_rdata0", rdata0, (m_rd == 0) ? m_rd_data : 32'd0);
      chk("m_rdata1", rdata1, (m_rd == 1) ? m_rd_data : 32'd0);
      w = pick(req0, req1);
      chk("m_gnt0", gnt0, w == 0);
      chk("m_gnt1", gnt1, w == 1);
      chk("m_men", mem_en, w >= 0);
      if (w >= 0) begin
        e_we    = (w == 0) ? we0 : we1;
        e_addr  = (w == 0) ? addr0 : addr1;
        e_wdata = (w == 0) ? wdata0 : wdata1;
        chk("m_mwe", mem_we, e_we);
        chk("m_maddr", mem_addr, e_addr);
        chk("m_mwdata", mem_wdata, e_wdata);
        if (e_we) begin
          ref_mem[e_addr[7:0]] = e_wdata;
          m_rd = -1;
        end else begin
          m_rd = w;
          m_rd_data = ref_mem[e_addr[7:0]];
        end
        m_streak = (w == m_owner) ? ((m_streak < MB) ? m_streak + 1 : MB) : 1;
        m_owner = w;
        m_last = w;
      end else begin
        chk("m_idle_mwe", mem_we, 0);
        chk("m_idle_maddr", mem_addr, 0);
        chk("m_idle_mwdata", mem_wdata, 0);
        m_owner = -1; m_streak = 0; m_rd = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic was0, was1;

  initial begin
    for (int i = 0; i < 256; i++) begin
      bmem[i] = 32'hA500_0000 + i;
      ref_mem[i] = 32'hA500_0000 + i;
    end
    bmem[8'h20] = 32'h11; ref_mem[8'h20] = 32'h11;
    bmem[8'h24] = 32'h22; ref_mem[8'h24] = 32'h22;

    // Reset with both ports requesting
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4; wdata0 = '0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h8; wdata1 = '0;
    tick(); tick();
    mid();
    chk("t1_gnt0", gnt0, 0);
    chk("t1_gnt1", gnt1, 0);
    chk("t1_men", mem_en, 0);
    chk("t1_rv0", rvalid0, 0);
    chk("t1_rv1", rvalid1, 0);
    tick();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();

    // Port 0 write then read back
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
    mid(); chk("t2_wr_gnt0", gnt0, 1);
    tick();
    we0 = 1'b0;
    mid(); chk("t2_rd_gnt0", gnt0, 1); chk("t2_wr_no_rv0", rvalid0, 0);
    tick();
    req0 = 1'b0;
    mid();
    chk("t2_rv0", rvalid0, 1);
    chk("t2_rdata0", rdata0, 32'hDEADBEEF);
    chk("t2_rv1", rvalid1, 0);

    // Interleaved reads on alternating ports
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
    mid(); chk("t4_gnt0", gnt0, 1);
    tick();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h24;
    mid();
    chk("t4_rv0", rvalid0, 1); chk("t4_rdata0", rdata0, 32'h11); chk("t4_gnt1", gnt1, 1);
    tick();
    req1 = 1'b0;
    mid();
    chk("t4_rv1", rvalid1, 1); chk("t4_rdata1", rdata1, 32'h22); chk("t4_rv0_off", rvalid0, 0);

    // Tie from IDLE with last=0
    tick();
    req0 = 1'b1; addr0 = 32'h0;
    mid(); chk("t5_pre_gnt0", gnt0, 1);
    tick(); req0 = 1'b0;
    tick(); req0 = 1'b1; req1 = 1'b1;
    mid();
    chk("t5_tie_gnt0", gnt0, !RR);
    chk("t5_tie_gnt1", gnt1, RR);
    tick(); req0 = 1'b0; req1 = 1'b0;

    // Burst cap with both ports held, starting from a fresh reset (last=1)
    rst = 1'b1; tick();
    rst = 1'b0; req0 = 1'b1; addr0 = 32'h1; req1 = 1'b1; addr1 = 32'h2;
    for (int i = 0; i < 16; i++) begin
      mid();
      chk("t3_gnt0", gnt0, ((i / MB) % 2) == 0);
      chk("t3_gnt1", gnt1, ((i / MB) % 2) == 1);
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Reset right after a granted port-1 read
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h24;
    mid(); chk("t6_gnt1", gnt1, 1);
    tick();
    rst = 1'b1; req1 = 1'b0;
    mid(); chk("t6_rv1_killed", rvalid1, 0);
    tick();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    mid(); chk("t6_idle_gnt0", gnt0, 1); chk("t6_idle_gnt1", gnt1, 0);
    tick();
    req0 = 1'b0; req1 = 1'b0;

    // Randomized traffic; requests held until granted, occasionally withdrawn
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      was0 = gnt0; was1 = gnt1;
      @(posedge clk);
      #1;
      if (req0 && !was0) begin
        if ($urandom % 16 == 0) req0 = 1'b0;
      end else begin
        req0 = ($urandom % 3) != 0; we0 = $urandom % 2;
        addr0 = {28'd0, 4'($urandom)}; wdata0 = $urandom;
      end
      if (req1 && !was1) begin
        if ($urandom % 16 == 0) req1 = 1'b0;
      end else begin
        req1 = ($urandom % 3) != 0; we1 = $urandom % 2;
        addr1 = {28'd0, 4'($urandom)}; wdata1 = $urandom;
      end
    end
    mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
